// File: rtl/cic_pkg.sv
// Shared types and arithmetic helpers for the CIC integrator chain.
package cic_pkg;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS2     = 3'd1,
    OS4     = 3'd2,
    OS8     = 3'd3,
    OS16    = 3'd4,
    OS32    = 3'd5,
    OS64    = 3'd6
  } os_sel_e;

  localparam int unsigned SUMW = 64;

  typedef struct packed {
    logic                   ovf;
    logic                   neg;
    logic signed [SUMW-1:0] value;
  } sat_res_t;

  // Width is capped at odw so an over-wide oversampling choice never exceeds the accumulator.
  function automatic logic [7:0] eff_width(input logic [2:0] os_sel, input int unsigned idw,
                                           input int unsigned nst, input int unsigned odw);
    int unsigned we;
    if (os_sel >= OS2 && os_sel <= OS64) we = idw + nst * 32'(os_sel);
    else                                 we = odw;
    if (we > odw) we = odw;
    return 8'(we);
  endfunction

  function automatic sat_res_t sat_wrap(input logic signed [SUMW-1:0] sum,
                                        input logic [7:0] we, input logic sat_mode);
    logic signed [SUMW-1:0] hi;
    logic signed [SUMW-1:0] lo;
    int unsigned            sh;
    sat_res_t               r;
    hi      = (64'sd1 <<< (we - 8'd1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    sh      = SUMW - 32'(we);
    r.neg   = sum[SUMW-1];
    r.ovf   = (sum > hi) || (sum < lo);
    if (!r.ovf)    r.value = sum;
    else if (sat_mode) r.value = r.neg ? lo : hi;
    else           r.value = (sum <<< sh) >>> sh;
    return r;
  endfunction

endpackage

// File: rtl/cic_integrator_chain_if.sv
// Sample stream into and out of the integrator chain.
interface cic_integrator_chain_if #(
  parameter int unsigned IDW = 16,
  parameter int unsigned ODW = 24,
  parameter int unsigned CHW = 1
);
  logic           in_valid;
  logic [CHW-1:0] in_ch;
  logic [IDW-1:0] data_in;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [ODW-1:0] data_out;

  modport master (output in_valid, in_ch, data_in, input out_valid, out_ch, data_out);
  modport slave  (input in_valid, in_ch, data_in, output out_valid, out_ch, data_out);
endinterface

// File: rtl/cic_integ_stage.sv
// One integrator stage: per-channel accumulators plus the valid/channel/value pipeline register.
module cic_integ_stage
  import cic_pkg::*;
#(
  parameter int unsigned ODW = 24,
  parameter int unsigned NCH = 2,
  parameter int unsigned CHW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_flush,
  input  logic [7:0]            i_we,
  input  logic                  i_sat,
  input  logic                  i_valid,
  input  logic [CHW-1:0]        i_ch,
  input  logic signed [ODW-1:0] i_x,
  output logic                  o_valid,
  output logic [CHW-1:0]        o_ch,
  output logic signed [ODW-1:0] o_y,
  output logic                  o_ovf,
  output logic                  o_neg,
  output logic [CHW-1:0]        o_ovf_ch
);
  localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

  logic signed [ODW-1:0]  r_acc [NCH];
  logic                   r_valid;
  logic [CHW-1:0]         r_ch;
  logic signed [ODW-1:0]  r_y;

  logic                   w_hit;
  logic signed [ODW-1:0]  w_cur;
  logic signed [ODW-1:0]  w_new;
  logic signed [ODW:0]    w_sum;
  logic signed [SUMW-1:0] w_sum_x;
  sat_res_t               w_res;
  logic                   w_unused_hi;

  always_comb begin
    w_hit   = i_valid && !i_flush && ({1'b0, i_ch} < NCH_L);
    w_cur   = w_hit ? r_acc[i_ch] : '0;
    w_sum   = {w_cur[ODW-1], w_cur} + {i_x[ODW-1], i_x};
    w_sum_x = {{(SUMW-ODW-1){w_sum[ODW]}}, w_sum};
    w_res   = sat_wrap(w_sum_x, i_we, i_sat);
    w_new   = w_res.value[ODW-1:0];
  end

  assign w_unused_hi = ^w_res.value[SUMW-1:ODW];

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned c = 0; c < NCH; c++) r_acc[c] <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_y     <= '0;
    end else if (i_flush) begin
      for (int unsigned c = 0; c < NCH; c++) r_acc[c] <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_hit;
      if (w_hit) begin
        r_acc[i_ch] <= w_new;
        r_ch        <= i_ch;
        r_y         <= w_new;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_ch     = r_ch;
  assign o_y      = r_y;
  assign o_ovf    = w_hit && w_res.ovf;
  assign o_neg    = w_res.neg;
  assign o_ovf_ch = i_ch;
endmodule

// File: rtl/cic_integrator_chain.sv
// NST-stage multi-channel CIC integrator with runtime width select, sat/wrap and sticky overflow flags.
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int unsigned IDW = 16,
  parameter int unsigned ODW = 24,
  parameter int unsigned NST = 3,
  parameter int unsigned NCH = 2,
  parameter int unsigned CHW = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             os_sel,
  input  logic                   sat_mode,
  input  logic                   clr_flags,
  cic_integrator_chain_if.slave  bus,
  output logic [NCH-1:0]         ovf_flag,
  output logic [NCH-1:0]         ovf_neg
);
  logic [2:0]                r_os_sel;
  logic                      r_sat_mode;
  logic                      w_flush;
  logic [7:0]                w_we;
  logic [NST:0]              w_valid;
  logic [NST:0][CHW-1:0]     w_ch;
  logic [NST:0][ODW-1:0]     w_x;
  logic [NST-1:0]            w_ovf;
  logic [NST-1:0]            w_neg;
  logic [NST-1:0][CHW-1:0]   w_ovf_ch;
  logic [NCH-1:0]            w_flag_nxt;
  logic [NCH-1:0]            w_neg_nxt;

  // Any mode change clears every stage for one cycle so no sample mixes two widths.
  assign w_flush = (os_sel != r_os_sel) || (sat_mode != r_sat_mode);
  assign w_we    = eff_width(os_sel, IDW, NST, ODW);

  assign w_valid[0] = bus.in_valid;
  assign w_ch[0]    = bus.in_ch;
  assign w_x[0]     = {{(ODW-IDW){bus.data_in[IDW-1]}}, bus.data_in};

  for (genvar k = 0; k < NST; k++) begin : g_stage
    cic_integ_stage #(.ODW(ODW), .NCH(NCH), .CHW(CHW)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_flush  (w_flush),
      .i_we     (w_we),
      .i_sat    (sat_mode),
      .i_valid  (w_valid[k]),
      .i_ch     (w_ch[k]),
      .i_x      (w_x[k]),
      .o_valid  (w_valid[k+1]),
      .o_ch     (w_ch[k+1]),
      .o_y      (w_x[k+1]),
      .o_ovf    (w_ovf[k]),
      .o_neg    (w_neg[k]),
      .o_ovf_ch (w_ovf_ch[k])
    );
  end

  assign bus.out_valid = w_valid[NST];
  assign bus.out_ch    = w_ch[NST];
  assign bus.data_out  = w_x[NST];

  // A clear drops old flags, but a same-cycle overflow still lands.
  always_comb begin
    w_flag_nxt = clr_flags ? '0 : ovf_flag;
    w_neg_nxt  = clr_flags ? '0 : ovf_neg;
    for (int unsigned k = 0; k < NST; k++) begin
      if (w_ovf[k]) begin
        w_flag_nxt[w_ovf_ch[k]] = 1'b1;
        w_neg_nxt[w_ovf_ch[k]]  = w_neg[k];
      end
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_os_sel   <= '0;
      r_sat_mode <= 1'b0;
      ovf_flag   <= '0;
      ovf_neg    <= '0;
    end else begin
      r_os_sel   <= os_sel;
      r_sat_mode <= sat_mode;
      ovf_flag   <= w_flag_nxt;
      ovf_neg    <= w_neg_nxt;
    end
  end
endmodule

// File: tb/tb_cic_integrator_chain.sv
// Directed bench for cic_integrator_chain; DUT flops on negedge, bench drives and samples on posedge.
module tb_cic_integrator_chain;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] os_sel;
  logic       sat_mode;
  logic       clr_flags;
  logic [1:0] ovf_flag;
  logic [1:0] ovf_neg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] oq_d[$];
  logic        oq_c[$];
  int          fv;
  logic        sv_c[$];
  logic [15:0] sv_d[$];

  always #5 clk = ~clk;

  cic_integrator_chain_if #(.IDW(16), .ODW(24), .CHW(1)) bus ();

  cic_integrator_chain #(.IDW(16), .ODW(24), .NST(3), .NCH(2), .CHW(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .os_sel    (os_sel),
    .sat_mode  (sat_mode),
    .clr_flags (clr_flags),
    .bus       (bus),
    .ovf_flag  (ovf_flag),
    .ovf_neg   (ovf_neg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] s24(input int v);
    logic [23:0] t;
    t = v[23:0];
    return {8'h00, t};
  endfunction

  task automatic add(input logic c, input logic [15:0] d);
    sv_c.push_back(c);
    sv_d.push_back(d);
  endtask

  task automatic run_stream();
    int n;
    n = sv_d.size();
    oq_d.delete();
    oq_c.delete();
    fv = -1;
    for (int i = 0; i < n + 6; i++) begin
      @(posedge clk);
      if (bus.out_valid) begin
        oq_d.push_back(bus.data_out);
        oq_c.push_back(bus.out_ch);
        if (fv < 0) fv = i;
      end
      if (i < n) begin
        bus.in_valid = 1'b1;
        bus.in_ch    = sv_c[i];
        bus.data_in  = sv_d[i];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    sv_c.delete();
    sv_d.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    clr_flags    = 1'b0;
    @(posedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int il_exp[6];
    int tri_exp[3];
    il_exp  = '{1, -1, 4, -4, 10, -10};
    tri_exp = '{1, 3, 6};

    reset_n      = 1'b0;
    os_sel       = 3'd3;
    sat_mode     = 1'b0;
    clr_flags    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch    = 1'b0;
    bus.data_in  = '0;

    repeat (2) @(posedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    check("rst_ovf_neg", ovf_neg, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Impulse, os_sel=3: triangular numbers of order 3
    add(0, 16'd1);
    for (int i = 0; i < 4; i++) add(0, 16'd0);
    run_stream();
    check("imp_latency", fv, 3);
    check("imp_count", oq_d.size(), 5);
    check("imp_y0", oq_d[0], s24(1));
    check("imp_y1", oq_d[1], s24(3));
    check("imp_y2", oq_d[2], s24(6));
    check("imp_y3", oq_d[3], s24(10));
    check("imp_y4", oq_d[4], s24(15));

    // Interleaved channels, ch0 +1 and ch1 -1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add(0, 16'h0001);
      add(1, 16'hFFFF);
    end
    run_stream();
    check("il_latency", fv, 3);
    check("il_count", oq_d.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check("il_data", oq_d[k], s24(il_exp[k]));
      check("il_ch", oq_c[k], k % 2);
    end

    // DC step, saturating, WE=19
    os_sel   = 3'd1;
    sat_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 12; i++) add(0, 16'h7FFF);
    run_stream();
    check("sat_count", oq_d.size(), 12);
    check("sat_y0", oq_d[0], s24(32767));
    check("sat_y1", oq_d[1], s24(131068));
    check("sat_y2", oq_d[2], s24(262143));
    check("sat_y11", oq_d[11], s24(262143));
    check("sat_ovf_flag", ovf_flag, 2'b01);
    check("sat_ovf_neg", ovf_neg, 2'b00);

    // DC step, wrapping, WE=19: 10*32767 wraps to -196618
    sat_mode = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) add(0, 16'h7FFF);
    run_stream();
    check("wrap_count", oq_d.size(), 3);
    check("wrap_y0", oq_d[0], s24(32767));
    check("wrap_y1", oq_d[1], s24(131068));
    check("wrap_y2", oq_d[2], s24(-196618));
    check("wrap_ovf_flag", ovf_flag, 2'b01);
    check("wrap_ovf_neg", ovf_neg, 2'b00);

    // Mode change with tokens in flight
    os_sel = 3'd3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      bus.in_valid = 1'b1;
      bus.in_ch    = 1'b0;
      bus.data_in  = (i == 0) ? 16'd1 : 16'd0;
    end
    @(posedge clk);
    check("mc_pre_valid", bus.out_valid, 1);
    check("mc_pre_data", bus.data_out, s24(1));
    os_sel      = 3'd4;
    bus.data_in = 16'd5;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      check("mc_gap_valid", bus.out_valid, 0);
      bus.in_valid = 1'b1;
      bus.data_in  = (j == 0) ? 16'd1 : 16'd0;
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      bus.in_valid = 1'b0;
      check("mc_post_valid", bus.out_valid, 1);
      check("mc_post_data", bus.data_out, s24(tri_exp[j]));
    end

    // clr_flags coincident with a new ch1 overflow
    os_sel   = 3'd1;
    sat_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      if (i == 7) check("clr_before", ovf_flag, 2'b01);
      bus.in_valid = (i < 6);
      bus.in_ch    = (i >= 3);
      bus.data_in  = 16'h7FFF;
      clr_flags    = (i == 7);
    end
    @(posedge clk);
    clr_flags = 1'b0;
    check("clr_after_flag", ovf_flag, 2'b10);
    check("clr_after_neg", ovf_neg, 2'b00);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      bus.in_valid = 1'b1;
      bus.in_ch    = 1'b0;
      bus.data_in  = 16'd100;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_data_out", bus.data_out, 0);
    check("arst_ovf_flag", ovf_flag, 0);
    @(posedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    add(1, 16'd7);
    run_stream();
    check("arst_post_latency", fv, 3);
    check("arst_post_count", oq_d.size(), 1);
    check("arst_post_data", oq_d[0], s24(7));
    check("arst_post_ch", oq_c[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
